// File: rtl/vga_pkg.sv
// Shared constants for the digit overlay: ROM source encodings, glyph size,
// digit field origin tables and the update handshake states.
package vga_pkg;

  typedef enum logic [1:0] {
    SEL_WHITE    = 2'd0,
    SEL_TEMPLATE = 2'd1,
    SEL_NUMEROS  = 2'd2,
    SEL_UNUSED   = 2'd3
  } rom_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_LOAD       = 2'd2,
    ST_ACK        = 2'd3
  } upd_state_e;

  localparam int GLYPH_SIZE  = 600;
  localparam int NUM_COLS    = 6;
  localparam int NUM_ROWS    = 3;
  localparam int NUM_NIBBLES = 18;

  // Template-relative X origin of each digit column.
  function automatic int field_col_x(input logic [2:0] c);
    case (c)
      3'd0:    return 32'sd2;
      3'd1:    return 32'sd24;
      3'd2:    return 32'sd52;
      3'd3:    return 32'sd74;
      3'd4:    return 32'sd100;
      3'd5:    return 32'sd122;
      default: return 32'sd0;
    endcase
  endfunction

  // Template-relative Y origin of each digit row: date, hour, timer.
  function automatic int field_row_y(input logic [1:0] r);
    case (r)
      2'd0:    return 32'sd20;
      2'd1:    return 32'sd70;
      2'd2:    return 32'sd120;
      default: return 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/digit_field_decode.sv
// Combinational pixel decode: template membership and offset, plus which
// digit field (row/column) the pixel falls in and its offset inside the glyph.
module digit_field_decode
  import vga_pkg::*;
#(
  parameter int IMG_X0  = 100,
  parameter int IMG_Y0  = 100,
  parameter int IMG_DIM = 200,
  parameter int DIG_W   = 20,
  parameter int DIG_H   = 30
) (
  input  logic [9:0] addrh,
  input  logic [9:0] addrv,
  output logic       in_tmpl,
  output logic [9:0] rel_x,
  output logic [9:0] rel_y,
  output logic       field_hit,
  output logic [1:0] row,
  output logic [2:0] col,
  output logic [9:0] off_x,
  output logic [9:0] off_y
);

  int   tx_s;
  int   ty_s;
  logic col_hit_s;
  logic row_hit_s;

  // Template window and template-relative offsets.
  always_comb begin
    tx_s    = int'(addrh) - IMG_X0;
    ty_s    = int'(addrv) - IMG_Y0;
    in_tmpl = (tx_s >= 32'sd0) && (tx_s < IMG_DIM) && (ty_s >= 32'sd0) && (ty_s < IMG_DIM);
    if (in_tmpl) begin
      rel_x = 10'(tx_s);
      rel_y = 10'(ty_s);
    end else begin
      rel_x = 10'd0;
      rel_y = 10'd0;
    end
  end

  // Column and row searches are independent; a field hit needs both.
  always_comb begin
    col_hit_s = 1'b0;
    col       = 3'd0;
    off_x     = 10'd0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!col_hit_s && (tx_s >= field_col_x(3'(c))) && (tx_s < field_col_x(3'(c)) + DIG_W)) begin
        col_hit_s = 1'b1;
        col       = 3'(c);
        off_x     = 10'(tx_s - field_col_x(3'(c)));
      end else begin
        col_hit_s = col_hit_s;
      end
    end
    row_hit_s = 1'b0;
    row       = 2'd0;
    off_y     = 10'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_hit_s && (ty_s >= field_row_y(2'(r))) && (ty_s < field_row_y(2'(r)) + DIG_H)) begin
        row_hit_s = 1'b1;
        row       = 2'(r);
        off_y     = 10'(ty_s - field_row_y(2'(r)));
      end else begin
        row_hit_s = row_hit_s;
      end
    end
    field_hit = col_hit_s && row_hit_s;
  end

endmodule

// File: rtl/digit_overlay_ctrl.sv
// Digit overlay controller: 2-stage pixel-source pipeline selecting white,
// template or numeros ROM, and a blank-synchronised shadow-register update.
module digit_overlay_ctrl
  import vga_pkg::*;
#(
  parameter int IMG_X0    = 100,
  parameter int IMG_Y0    = 100,
  parameter int IMG_DIM   = 200,
  parameter int DIG_W     = 20,
  parameter int DIG_H     = 30,
  parameter int V_VISIBLE = 480
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENclock,
  input  logic [9:0]  ADDRH,
  input  logic [9:0]  ADDRV,
  input  logic        UPD_REQ,
  input  logic [71:0] UPD_DATA,
  output logic        UPD_ACK,
  output logic [1:0]  ROM_SEL,
  output logic [15:0] PLANT_ADDR,
  output logic [12:0] NUM_ADDR,
  output logic        PIX_VALID
);

  logic       dec_in_tmpl_s;
  logic [9:0] dec_rel_x_s;
  logic [9:0] dec_rel_y_s;
  logic       dec_hit_s;
  logic [1:0] dec_row_s;
  logic [2:0] dec_col_s;
  logic [9:0] dec_off_x_s;
  logic [9:0] dec_off_y_s;
  logic [4:0] nib_idx_s;
  logic [3:0] digit_s;

  logic [71:0] shadow_r;
  upd_state_e  state_r;
  upd_state_e  state_next_s;
  logic        ack_r;

  logic       s1_valid_r;
  logic       s1_in_tmpl_r;
  logic [9:0] s1_rel_x_r;
  logic [9:0] s1_rel_y_r;
  logic       s1_hit_r;
  logic [3:0] s1_digit_r;
  logic [9:0] s1_off_x_r;
  logic [9:0] s1_off_y_r;

  rom_sel_e   sel_s;
  logic [15:0] plant_s;
  logic [12:0] num_s;
  rom_sel_e   rom_sel_r;
  logic [15:0] plant_r;
  logic [12:0] num_r;
  logic        pix_valid_r;

  digit_field_decode #(
    .IMG_X0 (IMG_X0),
    .IMG_Y0 (IMG_Y0),
    .IMG_DIM(IMG_DIM),
    .DIG_W  (DIG_W),
    .DIG_H  (DIG_H)
  ) u_decode (
    .addrh    (ADDRH),
    .addrv    (ADDRV),
    .in_tmpl  (dec_in_tmpl_s),
    .rel_x    (dec_rel_x_s),
    .rel_y    (dec_rel_y_s),
    .field_hit(dec_hit_s),
    .row      (dec_row_s),
    .col      (dec_col_s),
    .off_x    (dec_off_x_s),
    .off_y    (dec_off_y_s)
  );

  assign nib_idx_s = 5'(dec_row_s) * 5'd6 + 5'(dec_col_s);
  assign digit_s   = shadow_r[{nib_idx_s, 2'b00} +: 4];

  // Update handshake state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ack_r   <= (state_next_s == ST_ACK);
    end
  end

  // LOAD is left unconditionally so a load started on the last blank line completes.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (UPD_REQ) state_next_s = ST_WAIT_BLANK;
        else         state_next_s = ST_IDLE;
      end
      ST_WAIT_BLANK: begin
        if (int'(ADDRV) >= V_VISIBLE) state_next_s = ST_LOAD;
        else                          state_next_s = ST_WAIT_BLANK;
      end
      ST_LOAD: state_next_s = ST_ACK;
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Shadow digits change only in LOAD, which is reachable only from vertical blank.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_r <= {NUM_NIBBLES{4'hF}};
    end else if (state_r == ST_LOAD) begin
      shadow_r <= UPD_DATA;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Stage 1: capture decode and the digit value for this pixel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_r   <= 1'b0;
      s1_in_tmpl_r <= 1'b0;
      s1_rel_x_r   <= 10'd0;
      s1_rel_y_r   <= 10'd0;
      s1_hit_r     <= 1'b0;
      s1_digit_r   <= 4'hF;
      s1_off_x_r   <= 10'd0;
      s1_off_y_r   <= 10'd0;
    end else if (ENclock) begin
      s1_valid_r   <= 1'b1;
      s1_in_tmpl_r <= dec_in_tmpl_s;
      s1_rel_x_r   <= dec_rel_x_s;
      s1_rel_y_r   <= dec_rel_y_s;
      s1_hit_r     <= dec_hit_s;
      s1_digit_r   <= digit_s;
      s1_off_x_r   <= dec_off_x_s;
      s1_off_y_r   <= dec_off_y_s;
    end
  end

  // Source priority; blank nibbles (10-15) fall through to the template.
  always_comb begin
    sel_s   = SEL_WHITE;
    plant_s = 16'd0;
    num_s   = 13'd0;
    if (s1_hit_r && (s1_digit_r <= 4'd9)) begin
      sel_s = SEL_NUMEROS;
      num_s = 13'(int'(s1_digit_r) * GLYPH_SIZE + int'(s1_off_x_r) * DIG_H + int'(s1_off_y_r));
    end else if (s1_in_tmpl_r) begin
      sel_s   = SEL_TEMPLATE;
      plant_s = 16'(int'(s1_rel_x_r) * IMG_DIM + int'(s1_rel_y_r));
    end else begin
      sel_s = SEL_WHITE;
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rom_sel_r   <= SEL_WHITE;
      plant_r     <= 16'd0;
      num_r       <= 13'd0;
      pix_valid_r <= 1'b0;
    end else if (ENclock) begin
      rom_sel_r   <= sel_s;
      plant_r     <= plant_s;
      num_r       <= num_s;
      pix_valid_r <= s1_valid_r;
    end
  end

  assign UPD_ACK    = ack_r;
  assign ROM_SEL    = rom_sel_r;
  assign PLANT_ADDR = plant_r;
  assign NUM_ADDR   = num_r;
  assign PIX_VALID  = pix_valid_r;

endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// Scoreboard bench for digit_overlay_ctrl: random pixels and updates checked
// against a coordinate-level reference model of the overlay.
module tb_digit_overlay_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENclock;
  logic [9:0]  ADDRH;
  logic [9:0]  ADDRV;
  logic        UPD_REQ;
  logic [71:0] UPD_DATA;
  logic        UPD_ACK;
  logic [1:0]  ROM_SEL;
  logic [15:0] PLANT_ADDR;
  logic [12:0] NUM_ADDR;
  logic        PIX_VALID;

  typedef struct {
    int sel;
    int plant;
    int num;
    int h;
    int v;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   sh[18];
  int   nibs[18];
  int   col_org[6] = '{2, 24, 52, 74, 100, 122};
  int   row_org[3] = '{20, 70, 120};
  logic en_at_edge = 1'b0;

  always #5 CLK = ~CLK;

  digit_overlay_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENclock   (ENclock),
    .ADDRH     (ADDRH),
    .ADDRV     (ADDRV),
    .UPD_REQ   (UPD_REQ),
    .UPD_DATA  (UPD_DATA),
    .UPD_ACK   (UPD_ACK),
    .ROM_SEL   (ROM_SEL),
    .PLANT_ADDR(PLANT_ADDR),
    .NUM_ADDR  (NUM_ADDR),
    .PIX_VALID (PIX_VALID)
  );

  // Reference: what the display should show at screen pixel (h,v).
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int tx = h - 100;
    int ty = v - 100;
    e.sel = 0; e.plant = 0; e.num = 0; e.h = h; e.v = v;
    if (tx >= 0 && tx < 200 && ty >= 0 && ty < 200) begin
      e.sel = 1;
      e.plant = tx * 200 + ty;
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++)
        if (tx >= col_org[c] && tx < col_org[c] + 20 && ty >= row_org[r] && ty < row_org[r] + 30
            && sh[6*r+c] <= 9) begin
          e.sel = 2;
          e.plant = 0;
          e.num = sh[6*r+c] * 600 + (tx - col_org[c]) * 30 + (ty - row_org[r]);
        end
    return e;
  endfunction

  always @(posedge CLK) en_at_edge <= ENclock && !RST;

  // Monitor: each enabled edge with valid output consumes one expectation.
  always @(negedge CLK) begin
    if (en_at_edge && PIX_VALID) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: output sel=%0d with no pixel pending", ROM_SEL);
      end else begin
        mon_e = sb.pop_front();
        if (int'(ROM_SEL) != mon_e.sel || int'(PLANT_ADDR) != mon_e.plant || int'(NUM_ADDR) != mon_e.num) begin
          fails++;
          $display("FAIL pixel(%0d,%0d): got sel=%0d plant=%0d num=%0d, expected sel=%0d plant=%0d num=%0d",
                   mon_e.h, mon_e.v, ROM_SEL, PLANT_ADDR, NUM_ADDR, mon_e.sel, mon_e.plant, mon_e.num);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int h, input int v, input bit en);
    @(negedge CLK);
    ADDRH = 10'(h);
    ADDRV = 10'(v);
    ENclock = en;
    if (en) sb.push_back(model(h, v));
    @(posedge CLK);
    #1;
  endtask

  function automatic bit rnd_en();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic rand_pixels(input int n);
    int h, v, c, r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = $urandom_range(0, 5);
        r = $urandom_range(0, 2);
        h = 100 + col_org[c] + int'($urandom_range(0, 21)) - 1;
        v = 100 + row_org[r] + int'($urandom_range(0, 31)) - 1;
      end else begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end
      cyc(h, v, rnd_en());
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    ENclock = 1'b0;
    @(posedge CLK);
    #1;
    sb.delete();
    for (int k = 0; k < 18; k++) sh[k] = 15;
    check("rst_rom_sel", int'(ROM_SEL), 0);
    check("rst_plant_addr", int'(PLANT_ADDR), 0);
    check("rst_num_addr", int'(NUM_ADDR), 0);
    check("rst_pix_valid", int'(PIX_VALID), 0);
    check("rst_upd_ack", int'(UPD_ACK), 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic do_update(input int wait_v, input int wait_cycles);
    bit got;
    int at;
    logic [71:0] d;
    for (int k = 0; k < 18; k++) d[4*k +: 4] = 4'(nibs[k]);
    UPD_DATA = d;
    UPD_REQ = 1'b1;
    for (int i = 0; i < wait_cycles; i++) begin
      cyc($urandom_range(0, 639), (wait_v < 0) ? int'($urandom_range(0, 479)) : wait_v, rnd_en());
      check("ack_before_blank", int'(UPD_ACK), 0);
    end
    got = 1'b0;
    at = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc($urandom_range(0, 639), 480 + int'($urandom_range(0, 44)), rnd_en());
      if (UPD_ACK) begin
        got = 1'b1;
        at = i;
      end
    end
    check("ack_seen", int'(got), 1);
    check("ack_latency", at, 1);
    if (got) begin
      for (int k = 0; k < 18; k++) sh[k] = nibs[k];
      UPD_REQ = 1'b0;
      cyc($urandom_range(0, 639), 480, rnd_en());
      check("ack_one_cycle", int'(UPD_ACK), 0);
    end
  endtask

  initial begin
    RST = 1'b0; ENclock = 1'b0; ADDRH = 10'd0; ADDRV = 10'd0;
    UPD_REQ = 1'b0; UPD_DATA = 72'd0;
    for (int k = 0; k < 18; k++) sh[k] = 15;

    do_reset();
    cyc(150, 150, 1'b1);
    cyc(50, 50, 1'b1);
    rand_pixels(60);

    for (int k = 0; k < 18; k++) nibs[k] = $urandom_range(0, 15);
    nibs[0] = 3;
    do_update(200, 6);
    cyc(107, 127, 1'b1);
    rand_pixels(80);

    for (int k = 0; k < 18; k++) nibs[k] = $urandom_range(0, 9);
    nibs[7] = 12;
    do_update(-1, 4);
    cyc(100 + 24 + 3, 100 + 70 + 4, 1'b1);
    rand_pixels(60);

    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 18; k++) nibs[k] = $urandom_range(0, 15);
      do_update(-1, int'($urandom_range(1, 8)));
      rand_pixels(50);
    end

    // Reset in WAIT_BLANK with the request still asserted.
    for (int k = 0; k < 18; k++) UPD_DATA[4*k +: 4] = 4'($urandom_range(0, 9));
    UPD_REQ = 1'b1;
    for (int i = 0; i < 3; i++) cyc(150, 200, 1'b1);
    do_reset();
    UPD_REQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc($urandom_range(0, 639), 480 + int'($urandom_range(0, 40)), rnd_en());
      check("ack_after_abort", int'(UPD_ACK), 0);
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++) cyc(100 + col_org[c] + 4, 100 + row_org[r] + 9, 1'b1);
    rand_pixels(40);
    cyc(300, 300, 1'b1);
    @(negedge CLK);
    #1;
    check("pipeline_depth", sb.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
